// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: sequential PC generation, an in-flight request counter,
// stale-response dropping after redirects, and a small FIFO of fetched
// instructions presented to decode.

`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

module instruction_fetch_unit #(
    parameter logic [`DATA_WIDTH-1:0] RESET_PC = 64'h0,
    parameter int                     FQ_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    imem_req_valid,
    input  logic                    imem_req_ready,
    output logic [`DATA_WIDTH-1:0]  imem_req_addr,
    input  logic                    imem_resp_valid,
    input  logic [`INSTR_WIDTH-1:0] imem_resp_instr,
    input  logic                    redirect_valid,
    input  logic [`DATA_WIDTH-1:0]  redirect_pc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [`DATA_WIDTH-1:0]  out_pc,
    output logic [`INSTR_WIDTH-1:0] out_instr
);

    localparam int DW = `DATA_WIDTH;
    localparam int IW = `INSTR_WIDTH;
    localparam int CW = $clog2(FQ_DEPTH + 1);
    localparam int PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam logic [CW:0] DEPTH_L = FQ_DEPTH[CW:0];

    logic [DW-1:0] r_pc;
    logic [DW-1:0] r_resp_pc;     // PC belonging to the next response that will be kept
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_drop_cnt;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [DW-1:0] r_q_pc    [FQ_DEPTH];
    logic [IW-1:0] r_q_instr [FQ_DEPTH];

    logic          w_deq;
    logic          w_enq;
    logic          w_acc;
    logic          w_drop;
    logic [CW:0]   w_load;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == PW'(FQ_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Request admission: in-flight plus queued entries (after this cycle's
    // dequeue) must leave room so every returning response has a slot.
    always_comb begin
        w_deq          = (r_count != '0) && out_ready;
        w_load         = {1'b0, r_inflight} + {1'b0, r_count} - {{CW{1'b0}}, w_deq};
        imem_req_valid = rst_n && !redirect_valid && (w_load < DEPTH_L);
        w_acc          = imem_req_valid && imem_req_ready;
        w_drop         = imem_resp_valid && (r_drop_cnt != '0);
        w_enq          = imem_resp_valid && (r_drop_cnt == '0) && !redirect_valid;
    end

    assign imem_req_addr = r_pc;
    assign out_valid     = (r_count != '0);
    assign out_pc        = r_q_pc[r_head];
    assign out_instr     = r_q_instr[r_head];

    // Fetch PC, in-flight/drop accounting and queue pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_inflight <= '0;
            r_drop_cnt <= '0;
            r_count    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
        end else begin
            r_inflight <= r_inflight + CW'(w_acc) - CW'(imem_resp_valid);
            if (redirect_valid) begin
                r_pc       <= {redirect_pc[DW-1:2], 2'b00};
                r_resp_pc  <= {redirect_pc[DW-1:2], 2'b00};
                r_drop_cnt <= imem_resp_valid ? r_inflight - 1'b1 : r_inflight;
                r_count    <= '0;
                r_head     <= '0;
                r_tail     <= '0;
            end else begin
                if (w_acc) begin
                    r_pc <= r_pc + DW'(4);
                end
                if (w_drop) begin
                    r_drop_cnt <= r_drop_cnt - 1'b1;
                end
                if (w_enq) begin
                    r_resp_pc <= r_resp_pc + DW'(4);
                    r_tail    <= f_next(r_tail);
                end
                if (w_deq) begin
                    r_head <= f_next(r_head);
                end
                r_count <= r_count + CW'(w_enq) - CW'(w_deq);
            end
        end
    end

    // Queue storage; cleared on reset so the head reads zero while held in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FQ_DEPTH; i++) begin
                r_q_pc[i]    <= '0;
                r_q_instr[i] <= '0;
            end
        end else if (w_enq) begin
            r_q_pc[r_tail]    <= r_resp_pc;
            r_q_instr[r_tail] <= imem_resp_instr;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a fixed-latency memory model.

`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

module tb_instruction_fetch_unit;

    localparam int DW = `DATA_WIDTH;
    localparam int IW = `INSTR_WIDTH;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [DW-1:0] imem_req_addr;
    logic          imem_resp_valid;
    logic [IW-1:0] imem_resp_instr;
    logic          redirect_valid;
    logic [DW-1:0] redirect_pc;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_pc;
    logic [IW-1:0] out_instr;

    int n_cmp = 0;
    int n_err = 0;
    int lat   = 1;
    int waitn;

    logic          pv [4];
    logic [DW-1:0] pa [4];

    instruction_fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_instr (imem_resp_instr),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instr       (out_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] word(input logic [DW-1:0] a);
        case (a)
            64'h0:   return 32'h00100093;
            64'h4:   return 32'h00200113;
            64'h8:   return 32'h00308193;
            64'hC:   return 32'h00110213;
            default: return 32'hC000_0000 | a[31:0];
        endcase
    endfunction

    // Memory: accepted requests travel down a shift pipe; response taps stage lat-1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                pv[i] <= 1'b0;
                pa[i] <= '0;
            end
        end else begin
            pv[0] <= imem_req_valid && imem_req_ready;
            pa[0] <= imem_req_addr;
            for (int i = 1; i < 4; i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
            end
        end
    end

    always_comb begin
        imem_resp_valid = pv[lat-1];
        imem_resp_instr = pv[lat-1] ? word(pa[lat-1]) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [DW-1:0] pc);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_pc"}, out_pc, pc);
        chk({tag, "_instr"}, out_instr, word(pc));
    endtask

    task automatic wait_out(input string tag, input int limit);
        waitn = 0;
        while (!out_valid && waitn < limit) begin
            @(negedge clk);
            waitn++;
        end
        chk({tag, "_arrived"}, out_valid, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; lat = 1; imem_req_ready = 1'b1; out_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_req_valid", imem_req_valid, 0);

        // Streaming with 1-cycle memory
        rst_n = 1'b1; #1;
        chk("first_req_valid", imem_req_valid, 1);
        chk("first_req_addr", imem_req_addr, 0);
        @(negedge clk);
        chk("e1_out_valid", out_valid, 0);
        chk("e1_req_addr", imem_req_addr, 4);
        @(negedge clk); chk_out("s0", 64'h0);
        @(negedge clk); chk_out("s4", 64'h4);
        @(negedge clk); chk_out("s8", 64'h8);
        @(negedge clk); chk_out("sC", 64'hC);

        // Decode stall: queue fills to depth, requests stop
        out_ready = 1'b0; #1;
        chk("stall_req_valid_now", imem_req_valid, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_head_pc", out_pc, 64'hC);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_req_valid", imem_req_valid, 0);
        end
        out_ready = 1'b1; #1;
        chk("unstall_req_valid", imem_req_valid, 1);
        chk("unstall_req_addr", imem_req_addr, 64'h14);
        @(negedge clk); chk_out("d10", 64'h10);
        @(negedge clk); chk_out("d14", 64'h14);
        @(negedge clk); chk_out("d18", 64'h18);

        // Async reset while full
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("full_out_valid", out_valid, 1);
        chk("full_head_pc", out_pc, 64'h18);
        #2; rst_n = 1'b0; #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_out_pc", out_pc, 0);
        chk("async_out_instr", out_instr, 0);
        chk("async_req_valid", imem_req_valid, 0);

        // 3-cycle memory, redirect to 0x42 with two requests in flight
        lat = 3; out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; #1;
        chk("rs_req_addr", imem_req_addr, 0);
        chk("rs_req_valid", imem_req_valid, 1);
        @(negedge clk);
        chk("l3_req_addr", imem_req_addr, 4);
        @(negedge clk);
        chk("l3_full_inflight", imem_req_valid, 0);
        redirect_valid = 1'b1; redirect_pc = 64'h42; #1;
        chk("redir_req_valid", imem_req_valid, 0);
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("redir_req_addr", imem_req_addr, 64'h40);
        chk("redir_out_valid", out_valid, 0);
        wait_out("redir", 20);
        chk("redir_latency", waitn, 5);
        chk_out("r40", 64'h40);
        @(negedge clk); chk_out("r44", 64'h44);

        // Back-to-back redirects: the second wins
        redirect_valid = 1'b1; redirect_pc = 64'h100;
        @(negedge clk);
        redirect_pc = 64'h200;
        chk("b2b_flush", out_valid, 0);
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("b2b_req_addr", imem_req_addr, 64'h200);
        chk("b2b_out_valid", out_valid, 0);
        wait_out("b2b", 30);
        chk_out("b200", 64'h200);
        @(negedge clk); chk_out("b204", 64'h204);

        // Memory not ready: address held, then advances by 4
        @(negedge clk);
        rst_n = 1'b0; lat = 1; imem_req_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("hold_req_addr", imem_req_addr, 0);
            chk("hold_req_valid", imem_req_valid, 1);
        end
        imem_req_ready = 1'b1;
        @(negedge clk); chk("acc_req_addr", imem_req_addr, 4);
        @(negedge clk); chk_out("h0", 64'h0);

        // Redirect to the current fetch PC still drops the in-flight response
        chk("same_pc_addr", imem_req_addr, 8);
        redirect_valid = 1'b1; redirect_pc = 64'h8;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("same_flush", out_valid, 0);
        chk("same_req_addr", imem_req_addr, 8);
        wait_out("same", 10);
        chk_out("same8", 64'h8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
